// File: rtl/portb_pkg.sv
// Shared definitions for the port-B host master: command op encodings and FSM states.
// PORTB_READBACK_EN adds the CHK (write readback) state.
package portb_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL,
    ST_RD_WAIT,
`ifdef PORTB_READBACK_EN
    ST_RESP,
    ST_CHK
`else
    ST_RESP
`endif
  } state_t;

endpackage

// File: rtl/portb_rd_delay.sv
// RD_LAT-deep valid shift register: fire rises RD_LAT cycles after start,
// marking the cycle in which memOutput holds the data for the presented address.
module portb_rd_delay #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic fire
);

  logic [RD_LAT-1:0] stage_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= start;
      for (int i = 1; i < RD_LAT; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign fire = stage_reg[RD_LAT-1];

endmodule

// File: rtl/portb_host_master.sv
// Host-side master for CPU memory port B: turns WRITE/READ/FILL commands into port-B cycles.
// Optional macro PORTB_READBACK_EN adds a readback check after every written word.
module portb_host_master
  import portb_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      memData,
  output logic                  writeEnable,
  input  logic [WIDTH-1:0]      memOutput,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [WIDTH-1:0]        data_reg, data_next;
  logic [LEN_WIDTH-1:0]    cnt_reg, cnt_next;
  logic                    we_reg, we_next;
  logic                    done_reg, done_next;
  logic                    ready_reg, ready_next;
  logic                    launch_reg, launch_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic [WIDTH-1:0]        rsp_data_reg, rsp_data_next;
  logic [ADDR_WIDTH-1:0]   rsp_addr_reg, rsp_addr_next;
  logic                    fire;
`ifdef PORTB_READBACK_EN
  logic                    err_reg, err_next;
  logic [ADDR_WIDTH-1:0]   err_addr_reg, err_addr_next;
`endif

  // launch_reg is high in the first cycle the read address is on the port
  portb_rd_delay #(.RD_LAT(RD_LAT)) u_rd_delay (
    .clk   (clk),
    .reset (reset),
    .start (launch_reg),
    .fire  (fire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      data_reg      <= '0;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      done_reg      <= 1'b0;
      ready_reg     <= 1'b0;
      launch_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_addr_reg  <= '0;
`ifdef PORTB_READBACK_EN
      err_reg       <= 1'b0;
      err_addr_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      cnt_reg       <= cnt_next;
      we_reg        <= we_next;
      done_reg      <= done_next;
      ready_reg     <= ready_next;
      launch_reg    <= launch_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_addr_reg  <= rsp_addr_next;
`ifdef PORTB_READBACK_EN
      err_reg       <= err_next;
      err_addr_reg  <= err_addr_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    cnt_next       = cnt_reg;
    we_next        = 1'b0;
    done_next      = 1'b0;
    launch_next    = 1'b0;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_addr_next  = rsp_addr_reg;
`ifdef PORTB_READBACK_EN
    err_next       = err_reg;
    err_addr_next  = err_addr_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid && ready_reg) begin
          case (cmd_op)
            OP_WRITE: begin
              state_next = ST_WRITE;
              addr_next  = cmd_addr;
              data_next  = cmd_data;
              cnt_next   = '0;
              we_next    = 1'b1;
            end
            OP_FILL: begin
              if (cmd_len != '0) begin
                state_next = ST_FILL;
                addr_next  = cmd_addr;
                data_next  = cmd_data;
                cnt_next   = cmd_len - LEN_WIDTH'(1);
                we_next    = 1'b1;
              end else begin
                done_next = 1'b1;
              end
            end
            OP_READ: begin
              state_next  = ST_RD_WAIT;
              addr_next   = cmd_addr;
              launch_next = 1'b1;
            end
            default: done_next = 1'b1;
          endcase
        end
      end
      // cnt_reg counts words still to write after the current one
      ST_WRITE, ST_FILL: begin
`ifdef PORTB_READBACK_EN
        state_next  = ST_CHK;
        launch_next = 1'b1;
`else
        if (cnt_reg == '0) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = ST_FILL;
          addr_next  = addr_reg + ADDR_WIDTH'(1);
          cnt_next   = cnt_reg - LEN_WIDTH'(1);
          we_next    = 1'b1;
        end
`endif
      end
`ifdef PORTB_READBACK_EN
      ST_CHK: begin
        if (fire) begin
          if (memOutput != data_reg) begin
            err_next = 1'b1;
            if (!err_reg) err_addr_next = addr_reg;
          end
          if (cnt_reg == '0) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_FILL;
            addr_next  = addr_reg + ADDR_WIDTH'(1);
            cnt_next   = cnt_reg - LEN_WIDTH'(1);
            we_next    = 1'b1;
          end
        end
      end
`endif
      ST_RD_WAIT: begin
        if (fire) begin
          state_next     = ST_RESP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = memOutput;
          rsp_addr_next  = addr_reg;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // the done cycle itself never accepts, so the next command lands one cycle later
    ready_next = (state_next == ST_IDLE) && !done_next;
  end

  assign cmd_ready   = ready_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;
  assign addr        = addr_reg;
  assign memData     = data_reg;
  assign writeEnable = we_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_addr    = rsp_addr_reg;
`ifdef PORTB_READBACK_EN
  assign err         = err_reg;
  assign err_addr    = err_addr_reg;
`else
  assign err         = 1'b0;
  assign err_addr    = '0;
`endif

endmodule

// File: tb/tb_portb_host_master.sv
// Directed self-checking bench for portb_host_master with a synchronous-read bench RAM.
// With PORTB_READBACK_EN the RAM has bit 0 stuck at 0 for address 0x0003.
module tb_portb_host_master;
  import portb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr, cmd_data, cmd_len;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data, rsp_addr;
  logic        done, busy;
  logic [15:0] addr, memData;
  logic        writeEnable;
  logic [15:0] memOutput;
  logic        err;
  logic [15:0] err_addr;

  int errors = 0;
  int checks = 0;

  logic [15:0] ram [0:65535];
  logic [15:0] log_addr [$];
  logic [15:0] log_data [$];

  always #5 clk = ~clk;

  portb_host_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .done(done), .busy(busy), .addr(addr), .memData(memData), .writeEnable(writeEnable),
    .memOutput(memOutput), .err(err), .err_addr(err_addr)
  );

  // synchronous RAM, one cycle read latency, read-before-write
  always @(posedge clk) begin
    if (writeEnable) begin
      ram[addr] <= memData;
      log_addr.push_back(addr);
      log_data.push_back(memData);
    end
`ifdef PORTB_READBACK_EN
    memOutput <= (addr == 16'h0003) ? (ram[addr] & 16'hFFFE) : ram[addr];
`else
    memOutput <= ram[addr];
`endif
  end

  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] l);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_len = l;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    $display("cmd op=%0d addr=%h data=%h len=%0d accepted at %0t", op, a, d, l, $time);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b required 1", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
    cmd_len = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, done, busy, writeEnable, err} !== 6'b0 ||
        addr !== 16'h0 || memData !== 16'h0 || rsp_data !== 16'h0 || rsp_addr !== 16'h0 ||
        err_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b done=%b busy=%b we=%b err=%b addr=%h md=%h required all 0",
               cmd_ready, rsp_valid, done, busy, writeEnable, err, addr, memData);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
    $display("reset released, cmd_ready=%b", cmd_ready);
  endtask

  task automatic test_write();
    log_addr.delete(); log_data.delete();
    send(OP_WRITE, 16'h0010, 16'hBEEF, 16'd0);
    @(negedge clk);
    checks++;
    if (writeEnable !== 1'b1 || addr !== 16'h0010 || memData !== 16'hBEEF || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_cycle: we=%b addr=%h data=%h busy=%b required 1/0010/BEEF/1",
               writeEnable, addr, memData, busy);
    end
`ifndef PORTB_READBACK_EN
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || writeEnable !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_done: done=%b we=%b rdy=%b required 1/0/0", done, writeEnable, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_after_done: done=%b rdy=%b required 0/1", done, cmd_ready);
    end
`else
    wait_done("write");
`endif
    checks++;
    if (log_addr.size() != 1) begin
      errors++;
      $display("FAIL write_count: writes=%0d required 1", log_addr.size());
    end
  endtask

  task automatic test_read(input logic [15:0] a, input logic [15:0] exp);
    int n;
    bit we_seen;
    send(OP_READ, a, 16'h0, 16'd0);
    n = 0; we_seen = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 20) begin
      if (writeEnable !== 1'b0) we_seen = 1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_addr !== a || we_seen) begin
      errors++;
      $display("FAIL read_rsp: valid=%b data=%h addr=%h we_seen=%0d required 1/%h/%h/0",
               rsp_valid, rsp_data, rsp_addr, we_seen, exp, a);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_handshake: valid=%b busy=%b rdy=%b required 0/0/1", rsp_valid, busy, cmd_ready);
    end
    $display("read addr=%h data=%h", rsp_addr, rsp_data);
  endtask

  task automatic test_fill_wrap();
    logic [15:0] exp_addr [4];
    exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
    log_addr.delete(); log_data.delete();
    send(OP_FILL, 16'hFFFE, 16'h1234, 16'd4);
`ifndef PORTB_READBACK_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (writeEnable !== 1'b1 || addr !== exp_addr[i] || memData !== 16'h1234 || done !== 1'b0) begin
        errors++;
        $display("FAIL fill_cycle%0d: we=%b addr=%h data=%h done=%b required 1/%h/1234/0",
                 i, writeEnable, addr, memData, done, exp_addr[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL fill_done: done=%b we=%b required 1/0", done, writeEnable);
    end
`else
    wait_done("fill");
`endif
    checks++;
    if (log_addr.size() != 4) begin
      errors++;
      $display("FAIL fill_count: writes=%0d required 4", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_addr[i] !== exp_addr[i] || log_data[i] !== 16'h1234) begin
          errors++;
          $display("FAIL fill_log%0d: addr=%h data=%h required %h/1234", i, log_addr[i], log_data[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_no_write_op(input logic [1:0] op, input string name);
    log_addr.delete(); log_data.delete();
    send(op, 16'h0040, 16'hAAAA, 16'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || writeEnable !== 1'b0 || log_addr.size() != 0) begin
      errors++;
      $display("FAIL %s: done=%b we=%b writes=%0d required 1/0/0", name, done, writeEnable, log_addr.size());
    end
    $display("%s op=%0d done=%b", name, op, done);
  endtask

  task automatic test_backpressure();
    int n;
    send(OP_READ, 16'h0010, 16'h0, 16'd0);
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_addr !== 16'h0010 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h addr=%h rdy=%b required 1/BEEF/0010/0",
                 i, rsp_valid, rsp_data, rsp_addr, cmd_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_handshake: valid=%b busy=%b required 0/0", rsp_valid, busy);
    end
    $display("backpressure read released, data=%h", rsp_data);
  endtask

  task automatic test_readback();
`ifdef PORTB_READBACK_EN
    send(OP_FILL, 16'h0000, 16'h0001, 16'd6);
    wait_done("readback");
    checks++;
    if (err !== 1'b1 || err_addr !== 16'h0003) begin
      errors++;
      $display("FAIL readback_err: err=%b err_addr=%h required 1/0003", err, err_addr);
    end
    send(OP_WRITE, 16'h0020, 16'h0007, 16'd0);
    wait_done("readback_sticky");
    checks++;
    if (err !== 1'b1 || err_addr !== 16'h0003) begin
      errors++;
      $display("FAIL readback_sticky: err=%b err_addr=%h required 1/0003", err, err_addr);
    end
`else
    checks++;
    if (err !== 1'b0 || err_addr !== 16'h0000) begin
      errors++;
      $display("FAIL err_tied: err=%b err_addr=%h required 0/0000", err, err_addr);
    end
`endif
    $display("readback err=%b err_addr=%h", err, err_addr);
  endtask

  task automatic test_reset_mid_fill();
    int n0;
    log_addr.delete(); log_data.delete();
    send(OP_FILL, 16'h0100, 16'h5555, 16'd8);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (writeEnable !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || addr !== 16'h0) begin
      errors++;
      $display("FAIL midreset_async: we=%b busy=%b rdy=%b addr=%h required 0/0/0/0000",
               writeEnable, busy, cmd_ready, addr);
    end
    @(negedge clk);
    reset = 1'b1;
    n0 = log_addr.size();
    checks++;
    if (n0 != 1) begin
      errors++;
      $display("FAIL midreset_prior_writes: writes=%0d required 1", n0);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (log_addr.size() != n0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_after: writes=%0d busy=%b rdy=%b required %0d/0/1",
               log_addr.size(), busy, cmd_ready, n0);
    end
    $display("mid-fill reset: writes before reset=%0d", n0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(16'h0010, 16'hBEEF);
    test_fill_wrap();
    test_read(16'h0000, 16'h1234);
    test_no_write_op(OP_FILL, "fill_len0");
    test_no_write_op(OP_RSVD, "reserved_op");
    test_backpressure();
    test_readback();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
